dac_sigma_delta_mod2: RTL and testbench

Second-generation 1-bit sigma-delta DAC modulator with selectable loop order (1 or 2), saturating guard-bit integrators and an input-rate front end. Samples arrive via a valid/ready handshake at the audio rate. An OSR counter releases one held sample every OSR clocks to the modulator, which runs every clock. Sits between the sample source (FIFO/interpolator) and the pin driver; dac_o feeds an external RC/analog filter.

---
 rtl/dac_dsm_pkg.sv | 29 ++
 rtl/dsm_integrator_sat.sv | 47 ++++
 rtl/dac_sigma_delta_mod2.sv | 134 +++++++++++++
 tb/tb_dac_sigma_delta_mod2.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_dsm_pkg.sv
// dac_dsm_pkg
// Shared constants and elaboration-time helpers for the sigma-delta DAC
// modulator: internal integrator width, full-scale feedback value,
// saturation limits and the dither LFSR polynomial/seed.
package dac_dsm_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form:
  // the feedback bit is the XOR of state bits 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic int calc_bw_int(input int bw, input int guard);
    return bw + guard;
  endfunction

  // Feedback magnitude: 2^(bw-1), one LSB above the largest positive sample.
  function automatic longint calc_fs(input int bw);
    return longint'(1) <<< (bw - 1);
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/dsm_integrator_sat.sv
// dsm_integrator_sat
// One saturating integrator stage: acc_n = clamp(acc + delta), acc <= acc_n.
// The sum is formed two bits wider than the accumulator so it can never wrap
// before the clamp looks at it.
// Ports:
//   clk, rst  clock and asynchronous active-high reset (acc clears to 0)
//   delta     signed increment, W+2 bits
//   acc_n     clamped next value (combinational, also used by the next stage)
//   sat       high while the clamp is active this cycle
module dsm_integrator_sat
  import dac_dsm_pkg::*;
#(
  parameter int W = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W+1:0] delta,
  output logic signed [W-1:0] acc_n,
  output logic                sat
);

  localparam logic signed [W+1:0] ACC_MAX = (W+2)'(sat_max(W));
  localparam logic signed [W+1:0] ACC_MIN = (W+2)'(sat_min(W));

  logic signed [W-1:0] acc;
  logic signed [W+1:0] sum;

  assign sum = $signed({{2{acc[W-1]}}, acc}) + delta;

  always_comb begin
    acc_n = sum[W-1:0];
    sat   = 1'b0;
    if (sum > ACC_MAX) begin
      acc_n = ACC_MAX[W-1:0];
      sat   = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_n = ACC_MIN[W-1:0];
      sat   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc_n;
  end

endmodule

// File: rtl/dac_sigma_delta_mod2.sv
// dac_sigma_delta_mod2
// 1-bit sigma-delta DAC modulator, loop order 1 or 2, with saturating
// guard-bit integrators and a one-sample input buffer released every OSR
// clocks. The modulator itself runs every clock.
// Ports:
//   clk         clock
//   rst_i       asynchronous active-high reset
//   dac_i       signed input sample (BW bits)
//   in_valid_i  dac_i valid
//   in_ready_o  buffer empty, a sample can be accepted
//   dac_o       registered output bitstream
//   underrun_o  one-cycle pulse: a release tick found the buffer empty
//   sat_o       sticky: some integrator clamped since reset
// Build option: DSM_DITHER_EN adds the LSB of a 16-bit LFSR to the first
// integrator input to break up idle tones.
module dac_sigma_delta_mod2
  import dac_dsm_pkg::*;
#(
  parameter int BW    = 16,
  parameter int ORDER = 2,
  parameter int GUARD = 4,
  parameter int OSR   = 64
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic signed [BW-1:0] dac_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic                 dac_o,
  output logic                 underrun_o,
  output logic                 sat_o
);

  localparam int BW_INT = calc_bw_int(BW, GUARD);
  localparam int CW     = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic signed [BW_INT+1:0] FS_P = (BW_INT+2)'(calc_fs(BW));
  localparam logic signed [BW_INT-1:0] ZERO = '0;

  logic signed [BW-1:0]     smp_buf;
  logic                     buf_full;
  logic signed [BW-1:0]     x_reg;
  logic [CW-1:0]            osr_cnt;
  logic                     tick;
  logic                     accept;
  logic signed [BW_INT+1:0] x_ext;
  logic signed [BW_INT+1:0] y;
  logic signed [BW_INT+1:0] delta1;
  logic signed [BW_INT-1:0] int1_n;
  logic                     sat1;
  logic                     sat2;
  logic                     dac_next;

  // Ready depends on registered state only.
  assign in_ready_o = ~buf_full;
  assign accept     = in_valid_i & ~buf_full;
  assign tick       = (osr_cnt == CW'(OSR - 1));

  assign x_ext = {{(BW_INT + 2 - BW){x_reg[BW-1]}}, x_reg};
  assign y     = dac_o ? FS_P : -FS_P;

`ifdef DSM_DITHER_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  end

  assign delta1 = x_ext - y + $signed({{(BW_INT + 1){1'b0}}, lfsr[0]});
`else
  assign delta1 = x_ext - y;
`endif

  dsm_integrator_sat #(.W(BW_INT)) u_int1 (
    .clk   (clk),
    .rst   (rst_i),
    .delta (delta1),
    .acc_n (int1_n),
    .sat   (sat1)
  );

  if (ORDER == 2) begin : g_ord2
    logic signed [BW_INT+1:0] delta2;
    logic signed [BW_INT-1:0] int2_n;

    // Second stage sees the first stage's fresh value and twice the feedback.
    assign delta2 = $signed({{2{int1_n[BW_INT-1]}}, int1_n}) - (y <<< 1);

    dsm_integrator_sat #(.W(BW_INT)) u_int2 (
      .clk   (clk),
      .rst   (rst_i),
      .delta (delta2),
      .acc_n (int2_n),
      .sat   (sat2)
    );

    assign dac_next = (int2_n >= ZERO);
  end else if (ORDER == 1) begin : g_ord1
    assign sat2     = 1'b0;
    assign dac_next = (int1_n >= ZERO);
  end else begin : g_bad_order
    $error("dac_sigma_delta_mod2: ORDER must be 1 or 2");
  end

  if (OSR < 1) begin : g_bad_osr
    $error("dac_sigma_delta_mod2: OSR must be at least 1");
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      smp_buf    <= '0;
      buf_full   <= 1'b0;
      x_reg      <= '0;
      osr_cnt    <= '0;
      dac_o      <= 1'b0;
      underrun_o <= 1'b0;
      sat_o      <= 1'b0;
    end else begin
      osr_cnt    <= tick ? '0 : osr_cnt + CW'(1);
      underrun_o <= tick & ~buf_full;
      dac_o      <= dac_next;
      sat_o      <= sat_o | sat1 | sat2;
      // A release and an accept are exclusive: accept needs an empty buffer.
      if (tick && buf_full) begin
        x_reg    <= smp_buf;
        buf_full <= 1'b0;
      end else if (accept) begin
        smp_buf  <= dac_i;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dac_sigma_delta_mod2.sv
module tb_dac_sigma_delta_mod2;

  localparam int     BW    = 16;
  localparam int     GUARD = 4;
  localparam longint FS    = 64'sd32768;
  localparam longint LIM   = 64'sd1 <<< (BW + GUARD - 1);
  localparam int     M_ORDER [2] = '{1, 2};
  localparam int     M_OSR   [2] = '{1, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [BW-1:0] din0, din1;
  logic                 vld0, vld1;
  logic                 rdy0, rdy1, dac0, dac1, und0, und1, sat0, sat1;

  dac_sigma_delta_mod2 #(.BW(BW), .ORDER(1), .GUARD(GUARD), .OSR(1)) dut0 (
    .clk(clk), .rst_i(rst), .dac_i(din0), .in_valid_i(vld0), .in_ready_o(rdy0),
    .dac_o(dac0), .underrun_o(und0), .sat_o(sat0)
  );

  dac_sigma_delta_mod2 #(.BW(BW), .ORDER(2), .GUARD(GUARD), .OSR(4)) dut1 (
    .clk(clk), .rst_i(rst), .dac_i(din1), .in_valid_i(vld1), .in_ready_o(rdy1),
    .dac_o(dac1), .underrun_o(und1), .sat_o(sat1)
  );

  typedef struct {
    bit d;
    bit u;
    bit r;
    bit s;
    int x;
  } exp_t;

  exp_t expq0[$];
  exp_t expq1[$];
  exp_t e0, e1;
  int   rd0 = 0, rd1 = 0;
  int   tests_run = 0, tests_failed = 0;

  // Reference model state, plain integers.
  longint m_i1[2], m_i2[2];
  int     m_x[2], m_cyc[2], m_buf[2];
  bit     m_full[2], m_d[2], m_s[2];

  function automatic longint clamp(input longint v, output bit hit);
    hit = 1'b0;
    if (v > LIM - 1) begin hit = 1'b1; return LIM - 1; end
    if (v < -LIM)    begin hit = 1'b1; return -LIM; end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_i1[k] = 0; m_i2[k] = 0; m_x[k] = 0; m_cyc[k] = 0; m_buf[k] = 0;
      m_full[k] = 0; m_d[k] = 0; m_s[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit vld, input int din, output exp_t e);
    longint y, a, b;
    bit h1, h2, tick;
    y = m_d[k] ? FS : -FS;
    a = clamp(m_i1[k] + m_x[k] - y, h1);
    b = 0;
    h2 = 0;
    if (M_ORDER[k] == 2) b = clamp(m_i2[k] + a - 2 * y, h2);
    m_i1[k] = a;
    m_i2[k] = b;
    m_d[k]  = (M_ORDER[k] == 2) ? (b >= 0) : (a >= 0);
    m_s[k]  = m_s[k] | h1 | h2;
    tick = ((m_cyc[k] % M_OSR[k]) == M_OSR[k] - 1);
    m_cyc[k]++;
    e.u = tick && !m_full[k];
    if (tick && m_full[k]) begin
      m_x[k] = m_buf[k];
      m_full[k] = 0;
    end else if (vld && !m_full[k]) begin
      m_buf[k] = din;
      m_full[k] = 1;
    end
    e.d = m_d[k];
    e.r = !m_full[k];
    e.s = m_s[k];
    e.x = m_x[k];
  endtask

  // Stimulus side: every clock the model predicts what each DUT will show.
  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else begin
      model_step(0, vld0, int'(din0), e0);
      expq0.push_back(e0);
      model_step(1, vld1, int'(din1), e1);
      expq1.push_back(e1);
    end
  end

  task automatic chk(input string nm, input exp_t e, input bit d, input bit u,
                     input bit r, input bit s, input int x);
    tests_run++;
    if (d != e.d || u != e.u || r != e.r || s != e.s || x != e.x) begin
      tests_failed++;
      $display("FAIL %s t=%0t: got dac=%0b und=%0b rdy=%0b sat=%0b x=%0d, want dac=%0b und=%0b rdy=%0b sat=%0b x=%0d",
               nm, $time, d, u, r, s, x, e.d, e.u, e.r, e.s, e.x);
    end
  endtask

  // Monitor: compares every predicted response against the DUT outputs.
  always @(negedge clk) begin
    if (rst) begin
      rd0 = expq0.size();
      rd1 = expq1.size();
    end else begin
      while (rd0 < expq0.size()) begin
        chk("sb_ord1", expq0[rd0], dac0, und0, rdy0, sat0, int'(dut0.x_reg));
        rd0++;
      end
      while (rd1 < expq1.size()) begin
        chk("sb_ord2", expq1[rd1], dac1, und1, rdy1, sat1, int'(dut1.x_reg));
        rd1++;
      end
    end
  end

  task automatic check(input string nm, input longint act, input longint lo, input longint hi);
    tests_run++;
    if (act < lo || act > hi) begin
      tests_failed++;
      $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic logic signed [BW-1:0] rnd_sample();
    if ($urandom_range(0, 7) == 0) return BW'($urandom_range(0, 65535));
    return BW'(int'($urandom_range(0, 16383)) - 8192);
  endfunction

  bit pat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  int ones0, ones1, unds, n;

  initial begin
    rst = 1'b1; vld0 = 1'b0; vld1 = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(negedge clk);
    check("rst_dac0", dac0, 0, 0);
    check("rst_dac1", dac1, 0, 0);
    check("rst_und1", und1, 0, 0);
    check("rst_sat1", sat1, 0, 0);
    check("rst_rdy1", rdy1, 1, 1);

    // Order 1 idle pattern and density; order 2 at half scale.
    vld0 = 1'b1; din0 = '0;
    vld1 = 1'b1; din1 = 16'sd16384;
    rst = 1'b0;
    ones0 = 0; ones1 = 0;
    for (int c = 0; c < 4112; c++) begin
      @(negedge clk);
      if (c < 5) check($sformatf("pat_%0d", c), dac0, pat[c], pat[c]);
      if (c < 1024) ones0 += int'(dac0);
      if (c >= 16) ones1 += int'(dac1);
    end
    check("ord1_ones_1024", ones0, 511, 513);
    check("ord2_ones_4096", ones1, 3072 - 41, 3072 + 41);
    check("ord1_sat", sat0, 0, 0);
    check("ord2_sat_half", sat1, 0, 0);

    // Back-to-back samples with valid held high: no underrun.
    unds = 0;
    foreach (pat[i]) begin end
    for (int i = 0; i < 3; i++) begin
      din1 = BW'(100 * (i + 1));
      n = 0;
      while (!rdy1 && n < 20) begin
        @(negedge clk);
        unds += int'(und1);
        n++;
      end
      check($sformatf("accept_wait_%0d", i), n, 0, 19);
      @(negedge clk);
      unds += int'(und1);
    end
    check("stream_underruns", unds, 0, 0);

    // Withhold valid: the last sample repeats and ticks flag underruns.
    vld1 = 1'b0;
    unds = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      unds += int'(und1);
    end
    check("hold_x", int'(dut1.x_reg), 300, 300);
    check("hold_underruns", unds, 3, 5);
    vld1 = 1'b1; din1 = 16'sd400;
    @(negedge clk);
    vld1 = 1'b0;
    n = 0;
    while (int'(dut1.x_reg) != 400 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reload_wait", n, 0, 9);

    // Randomised traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      vld0 = ($urandom_range(0, 3) != 0);
      din0 = rnd_sample();
      vld1 = ($urandom_range(0, 3) != 0);
      din1 = rnd_sample();
      @(negedge clk);
    end

    // Near full scale, then back to zero.
    vld0 = 1'b1; din0 = '0;
    vld1 = 1'b1; din1 = 16'sd32767;
    ones1 = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c >= 20) ones1 += int'(dac1);
    end
    check("fullscale_ones", ones1, 1881, 1980);
    din1 = '0;
    repeat (200) @(negedge clk);
    ones1 = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      ones1 += int'(dac1);
    end
    check("recover_ones", ones1, 480, 520);

    // Asynchronous reset between edges while a sample is buffered.
    din1 = 16'sd1234; vld1 = 1'b1;
    n = 0;
    while (rdy1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("buf_full_wait", n, 0, 19);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_dac0", dac0, 0, 0);
    check("arst_dac1", dac1, 0, 0);
    check("arst_und0", und0, 0, 0);
    check("arst_und1", und1, 0, 0);
    check("arst_sat0", sat0, 0, 0);
    check("arst_sat1", sat1, 0, 0);
    check("arst_rdy1", rdy1, 1, 1);
    check("arst_x1", int'(dut1.x_reg), 0, 0);
    repeat (2) @(negedge clk);
    vld0 = 1'b1; din0 = '0;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("repat_%0d", c), dac0, pat[c], pat[c]);
    end
    for (int c = 0; c < 60; c++) begin
      vld1 = ($urandom_range(0, 1) != 0);
      din1 = rnd_sample();
      @(negedge clk);
    end
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
